// File: rtl/blit_pkg.sv
// Shared types and default geometry for the sprite blitter (FSM states, signed coordinates).
package blit_pkg;

  localparam int DEF_SPR_W  = 100;
  localparam int DEF_SPR_H  = 100;
  localparam int DEF_FB_W   = 320;
  localparam int DEF_FB_H   = 240;
  localparam int DEF_ROM_AW = 14;
  localparam int DEF_FB_AW  = 17;
  localparam int DEF_PIX_W  = 8;

  typedef logic signed [10:0] coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } blit_state_t;

endpackage

// File: rtl/blit_addr_gen.sv
// Sprite raster walker: sx/sy counters, linear ROM address and last-pixel flag.
module blit_addr_gen
  import blit_pkg::*;
#(
  parameter int SPR_W  = DEF_SPR_W,
  parameter int SPR_H  = DEF_SPR_H,
  parameter int ROM_AW = DEF_ROM_AW
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       clear_i,
  input  logic                       advance_i,
  output logic [$clog2(SPR_W)-1:0]   sx_o,
  output logic [$clog2(SPR_H)-1:0]   sy_o,
  output logic [ROM_AW-1:0]          rom_addr_o,
  output logic                       last_o
);

  localparam int SXW = $clog2(SPR_W);
  localparam int SYW = $clog2(SPR_H);
  localparam logic [SXW-1:0] SX_MAX = SXW'(SPR_W - 1);
  localparam logic [SYW-1:0] SY_MAX = SYW'(SPR_H - 1);

  logic [SXW-1:0]    sx_q, sx_d;
  logic [SYW-1:0]    sy_q, sy_d;
  logic [ROM_AW-1:0] addr_q, addr_d;

  // The address is a running count, so sy*SPR_W + sx never needs a multiplier.
  always_comb begin
    sx_d   = sx_q;
    sy_d   = sy_q;
    addr_d = addr_q;
    if (clear_i) begin
      sx_d   = '0;
      sy_d   = '0;
      addr_d = '0;
    end else if (advance_i) begin
      addr_d = addr_q + 1'b1;
      if (sx_q == SX_MAX) begin
        sx_d = '0;
        sy_d = sy_q + 1'b1;
      end else begin
        sx_d = sx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sx_q   <= '0;
      sy_q   <= '0;
      addr_q <= '0;
    end else begin
      sx_q   <= sx_d;
      sy_q   <= sy_d;
      addr_q <= addr_d;
    end
  end

  assign sx_o       = sx_q;
  assign sy_o       = sy_q;
  assign rom_addr_o = addr_q;
  assign last_o     = (sx_q == SX_MAX) && (sy_q == SY_MAX);

endmodule

// File: rtl/sprite_blitter.sv
// Copies one sprite from ROM into the frame buffer at a signed offset, clipping off-screen pixels.
// Optional BLIT_TRANSPARENCY_EN: pixels equal to TRANS_IDX are not written.
module sprite_blitter
  import blit_pkg::*;
#(
  parameter int SPR_W  = DEF_SPR_W,
  parameter int SPR_H  = DEF_SPR_H,
  parameter int FB_W   = DEF_FB_W,
  parameter int FB_H   = DEF_FB_H,
  parameter int ROM_AW = DEF_ROM_AW,
  parameter int FB_AW  = DEF_FB_AW,
  parameter int PIX_W  = DEF_PIX_W
`ifdef BLIT_TRANSPARENCY_EN
  ,
  parameter int TRANS_IDX = 0
`endif
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [10:0]       dest_x,
  input  logic [10:0]       dest_y,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_q,
  output logic              fb_we,
  output logic [FB_AW-1:0]  fb_addr,
  output logic [PIX_W-1:0]  fb_data
);

  localparam int SXW = $clog2(SPR_W);
  localparam int SYW = $clog2(SPR_H);
  localparam logic signed [11:0] FB_W_S = 12'(FB_W);
  localparam logic signed [11:0] FB_H_S = 12'(FB_H);
  localparam logic [FB_AW-1:0]   FB_W_A = FB_AW'(FB_W);

  blit_state_t state_q, state_d;
  coord_t      dx_q, dy_q;
  logic        done_q, done_d;
  logic        accept, clear, advance, last;
  logic [SXW-1:0] sx;
  logic [SYW-1:0] sy;

  logic              pipe_vld_q;
  logic signed [11:0] px_q, py_q, px_d, py_d;
  logic [FB_AW-1:0]  wr_addr_q, new_addr;
  logic [PIX_W-1:0]  wr_data_q;
  logic              in_bounds, opaque;

  blit_addr_gen #(
    .SPR_W  (SPR_W),
    .SPR_H  (SPR_H),
    .ROM_AW (ROM_AW)
  ) u_addr_gen (
    .clk        (vga_clk),
    .srst       (reset),
    .clear_i    (clear),
    .advance_i  (advance),
    .sx_o       (sx),
    .sy_o       (sy),
    .rom_addr_o (rom_addr),
    .last_o     (last)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    clear   = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          clear   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        advance = 1'b1;
        if (last) state_d = DRAIN;
      end
      DRAIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Screen coordinates travel one cycle behind the ROM address so they meet rom_q.
  assign px_d = {dx_q[10], dx_q} + 12'(sx);
  assign py_d = {dy_q[10], dy_q} + 12'(sy);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      dx_q       <= '0;
      dy_q       <= '0;
      pipe_vld_q <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      pipe_vld_q <= (state_q == RUN);
      px_q       <= px_d;
      py_q       <= py_d;
      if (accept) begin
        dx_q <= coord_t'(dest_x);
        dy_q <= coord_t'(dest_y);
      end
      if (fb_we) begin
        wr_addr_q <= new_addr;
        wr_data_q <= rom_q;
      end
    end
  end

  assign in_bounds = (px_q >= 12'sd0) && (px_q < FB_W_S) &&
                     (py_q >= 12'sd0) && (py_q < FB_H_S);

`ifdef BLIT_TRANSPARENCY_EN
  assign opaque = (rom_q != PIX_W'(TRANS_IDX));
`else
  assign opaque = 1'b1;
`endif

  // Only consumed when in_bounds, where py*FB_W + px always fits in FB_AW bits.
  assign new_addr = FB_AW'($unsigned(py_q)) * FB_W_A + FB_AW'($unsigned(px_q));

  assign fb_we   = pipe_vld_q && in_bounds && opaque;
  assign fb_addr = fb_we ? new_addr : wr_addr_q;
  assign fb_data = fb_we ? rom_q    : wr_data_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule
